divider_restoring: RTL and testbench

Sequential restoring divider for the arithmetic datapath, the inverse of the team's sequential multiplier. It takes a 2W-bit dividend, such as a multiplier product, and a W-bit divisor. It produces a W-bit quotient and a W-bit remainder, one quotient bit per clock. A start/busy/done handshake lets an FPU mantissa-division controller drive it.

---
 rtl/divider_restoring.sv | 154 +++++++++++++++
 tb/tb_divider_restoring.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/divider_restoring.sv
// Sequential restoring divider: a 2*WIDTH-bit unsigned dividend divided by a WIDTH-bit divisor,
// one quotient bit per clock, with a start/busy/done handshake and divide-by-zero / overflow flags.
module divider_restoring #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] qsh_q, qsh_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   trial_s;
    logic             qbit_s;

    // Next-state, datapath step and result loading.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        lo_d        = lo_q;
        qsh_d       = qsh_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;
        trial_s     = {r_q[WIDTH-1:0], lo_q[WIDTH-1]};
        qbit_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d       = divisor;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    quotient_d  = {WIDTH{1'b0}};
                    remainder_d = {WIDTH{1'b0}};
                    if (divisor == {WIDTH{1'b0}}) begin
                        dbz_d      = 1'b1;
                        quotient_d = {WIDTH{1'b1}};
                        state_d    = FIN;
                    end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
                        // Upper half not below the divisor means the quotient needs more than WIDTH bits.
                        ovf_d      = 1'b1;
                        quotient_d = {WIDTH{1'b1}};
                        state_d    = FIN;
                    end else begin
                        r_d     = {1'b0, dividend[2*WIDTH-1:WIDTH]};
                        lo_d    = dividend[WIDTH-1:0];
                        qsh_d   = {WIDTH{1'b0}};
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (trial_s >= {1'b0, div_q}) begin
                    r_d    = trial_s - {1'b0, div_q};
                    qbit_s = 1'b1;
                end else begin
                    r_d    = trial_s;
                    qbit_s = 1'b0;
                end
                lo_d  = lo_q << 1;
                qsh_d = WIDTH'({qsh_q, qbit_s});
                if (cnt_q == {CW{1'b0}}) begin
                    quotient_d  = qsh_d;
                    remainder_d = r_d[WIDTH-1:0];
                    state_d     = FIN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            r_q         <= {(WIDTH+1){1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            qsh_q       <= {WIDTH{1'b0}};
            div_q       <= {WIDTH{1'b0}};
            cnt_q       <= {CW{1'b0}};
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            lo_q        <= lo_d;
            qsh_q       <= qsh_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_divider_restoring.sv
// Directed and exhaustive checks of divider_restoring at WIDTH=3 and WIDTH=4.
module tb_divider_restoring;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic       start3 = 1'b0;
    logic [5:0] dd3 = 6'd0;
    logic [2:0] dv3 = 3'd0;
    logic [2:0] q3, r3;
    logic       busy3, done3, z3, o3;

    logic       start4 = 1'b0;
    logic [7:0] dd4 = 8'd0;
    logic [3:0] dv4 = 4'd0;
    logic [3:0] q4, r4;
    logic       busy4, done4, z4, o4;

    divider_restoring #(.WIDTH(3)) dut3 (
        .clk(clk), .rstn(rstn), .start(start3), .dividend(dd3), .divisor(dv3),
        .quotient(q3), .remainder(r3), .busy(busy3), .done(done3),
        .div_by_zero(z3), .overflow(o3)
    );

    divider_restoring #(.WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .dividend(dd4), .divisor(dv4),
        .quotient(q4), .remainder(r4), .busy(busy4), .done(done4),
        .div_by_zero(z4), .overflow(o4)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [5:0] dd;
        logic [2:0] dv;
        logic [2:0] q;
        logic [2:0] r;
        logic       z;
        logic       o;
        int         lat;
    } vec_t;

    // Runs one WIDTH=3 operation; lat counts cycles from the start cycle to the done cycle.
    // Returns positioned in the IDLE cycle after FIN.
    task automatic op3(input logic [5:0] dd, input logic [2:0] dv,
                       output logic [2:0] q, output logic [2:0] r,
                       output logic z, output logic o, output int lat);
        @(negedge clk);
        dd3 = dd; dv3 = dv; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 1;
        chk("busy_after_start", int'(busy3), 1);
        while (!done3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done3) chk("timeout3", 0, 1);
        q = q3; r = r3; z = z3; o = o3;
        @(posedge clk); #1;
        chk("done_single_pulse", int'(done3), 0);
        chk("busy_after_fin", int'(busy3), 0);
    endtask

    task automatic op4(input logic [7:0] dd, input logic [3:0] dv,
                       output logic [3:0] q, output logic [3:0] r,
                       output logic z, output logic o, output int lat);
        @(negedge clk);
        dd4 = dd; dv4 = dv; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done4) chk("timeout4", 0, 1);
        q = q4; r = r4; z = z4; o = o4;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t       vecs[10];
        logic [2:0] q, r;
        logic [3:0] qq, rr;
        logic       z, o;
        int         lat;
        int         eq, er, ez, eo, max;
        int         bad;

        vecs[0] = '{6'd49, 3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 4};
        vecs[1] = '{6'd17, 3'd3, 3'd5, 3'd2, 1'b0, 1'b0, 4};
        vecs[2] = '{6'd42, 3'd7, 3'd6, 3'd0, 1'b0, 1'b0, 4};
        vecs[3] = '{6'd20, 3'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1};
        vecs[4] = '{6'd56, 3'd7, 3'd7, 3'd0, 1'b0, 1'b1, 1};
        vecs[5] = '{6'd0,  3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 4};
        vecs[6] = '{6'd55, 3'd7, 3'd7, 3'd6, 1'b0, 1'b0, 4};
        vecs[7] = '{6'd8,  3'd1, 3'd7, 3'd0, 1'b0, 1'b1, 1};
        vecs[8] = '{6'd7,  3'd1, 3'd7, 3'd0, 1'b0, 1'b0, 4};
        vecs[9] = '{6'd0,  3'd0, 3'd7, 3'd0, 1'b1, 1'b0, 1};

        #2;
        chk("reset_quotient", int'(q3), 0);
        chk("reset_remainder", int'(r3), 0);
        chk("reset_busy", int'(busy3), 0);
        chk("reset_done", int'(done3), 0);
        chk("reset_flags", int'({z3, o3}), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            op3(vecs[i].dd, vecs[i].dv, q, r, z, o, lat);
            chk($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d_dbz", i), int'(z), int'(vecs[i].z));
            chk($sformatf("vec%0d_ovf", i), int'(o), int'(vecs[i].o));
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // start during CALC must be ignored.
        @(negedge clk);
        dd3 = 6'd49; dv3 = 3'd7; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(negedge clk);
        dd3 = 6'd20; dv3 = 3'd3; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = 2;
        while (!done3 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hs_latency", lat, 4);
        chk("hs_quotient", int'(q3), 7);
        chk("hs_remainder", int'(r3), 0);
        @(posedge clk); #1;
        chk("hs_idle_after_fin", int'(busy3), 0);
        op3(6'd17, 3'd3, q, r, z, o, lat);
        chk("hs_next_quotient", int'(q), 5);
        chk("hs_next_remainder", int'(r), 2);
        chk("hs_next_latency", lat, 4);

        // Reset in the middle of CALC.
        @(negedge clk);
        dd3 = 6'd49; dv3 = 3'd7; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy3), 0);
        chk("rst_mid_done", int'(done3), 0);
        chk("rst_mid_quotient", int'(q3), 0);
        chk("rst_mid_remainder", int'(r3), 0);
        chk("rst_mid_flags", int'({z3, o3}), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done3 || busy3) bad++;
        end
        chk("rst_hold_no_done", bad, 0);
        rstn = 1'b1;
        op3(6'd17, 3'd3, q, r, z, o, lat);
        chk("rst_after_quotient", int'(q), 5);
        chk("rst_after_remainder", int'(r), 2);

        // Exhaustive against / and %.
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 8; b++) begin
                op3(6'(a), 3'(b), q, r, z, o, lat);
                max = 7;
                if (b == 0) begin ez = 1; eo = 0; eq = max; er = 0; end
                else if (a / b > max) begin ez = 0; eo = 1; eq = max; er = 0; end
                else begin ez = 0; eo = 0; eq = a / b; er = a % b; end
                chk($sformatf("exh3_%0d_%0d", a, b),
                    int'({z, o, q, r}), (ez << 7) | (eo << 6) | (eq << 3) | er);
            end
        end
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(8'(a), 4'(b), qq, rr, z, o, lat);
                max = 15;
                if (b == 0) begin ez = 1; eo = 0; eq = max; er = 0; end
                else if (a / b > max) begin ez = 0; eo = 1; eq = max; er = 0; end
                else begin ez = 0; eo = 0; eq = a / b; er = a % b; end
                chk($sformatf("exh4_%0d_%0d", a, b),
                    int'({z, o, qq, rr}), (ez << 9) | (eo << 8) | (eq << 4) | er);
                chk($sformatf("exh4_lat_%0d_%0d", a, b), lat, (ez | eo) ? 1 : 5);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
